// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if
//   Bundles every non-clock signal of the front-end pipeline register bank.
//   master : the surrounding core (hazard unit, fetch and decode logic).
//            Drives the hazard controls and the F/D stage data, and observes the
//            D/E stage registers and the debug counters.
//   slave  : the register bank itself.
//   Hazard controls : StallF, StallD, FlushE, PCSrcD, CountClr
//   Fetch inputs    : PCNextF, InstrF, PCPlus4F
//   Decode inputs   : CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD
//   D outputs       : PCF, InstrD, PCPlus4D, ValidD
//   E outputs       : CtrlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, ValidE
//   Debug outputs   : StallCnt, FlushCnt
interface pipe_front_regs_if #(
  parameter int CTRL_W  = 10,
  parameter int COUNT_W = 16
);
  logic               StallF, StallD, FlushE, PCSrcD, CountClr;
  logic [31:0]        PCNextF, InstrF, PCPlus4F;
  logic [31:0]        PCF, InstrD, PCPlus4D;
  logic               ValidD;
  logic [CTRL_W-1:0]  CtrlD, CtrlE;
  logic [31:0]        RD1D, RD2D, SignImmD;
  logic [31:0]        RD1E, RD2E, SignImmE;
  logic [4:0]         RsD, RtD, RdD, RsE, RtE, RdE;
  logic               ValidE;
  logic [COUNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output StallF, StallD, FlushE, PCSrcD, CountClr,
    output PCNextF, InstrF, PCPlus4F,
    output CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    input  PCF, InstrD, PCPlus4D, ValidD,
    input  CtrlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, ValidE,
    input  StallCnt, FlushCnt
  );

  modport slave (
    input  StallF, StallD, FlushE, PCSrcD, CountClr,
    input  PCNextF, InstrF, PCPlus4F,
    input  CtrlD, RD1D, RD2D, RsD, RtD, RdD, SignImmD,
    output PCF, InstrD, PCPlus4D, ValidD,
    output CtrlE, RD1E, RD2E, RsE, RtE, RdE, SignImmE, ValidE,
    output StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_front_regs.sv
// pipe_front_regs
//   PC, IF/ID and ID/EX pipeline registers of the 5-stage MIPS core, with
//   stage-valid bits and saturating stall/flush event counters for debug.
//   Every output is a flop, so there is no combinational input-to-output path.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; PCF goes to PC_RESET, all else to 0
//   bus   : pipe_front_regs_if.slave (hazard controls, F/D/E stage data, counters)
// Parameters
//   PC_RESET : fetch PC after reset
//   CTRL_W   : width of the decoded control bundle (must match the interface)
//   COUNT_W  : width of each saturating counter (must match the interface)
module pipe_front_regs #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CTRL_W   = 10,
  parameter int          COUNT_W  = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_front_regs_if.slave bus
);

  logic stallEvt;
  logic flushEvt;

  // Saturating increment: the counter sticks at all-ones and never wraps.
  function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + COUNT_W'(1);
    end
  endfunction

  // Counter events. A squash from PCSrcD is not taken while D is stalled,
  // so it only counts when StallD is low; both terms together count once.
  always_comb begin
    stallEvt = bus.StallF | bus.StallD;
    flushEvt = bus.FlushE | (bus.PCSrcD & ~bus.StallD);
  end

  // PC register: holds while fetch is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.PCF <= PC_RESET;
    end else if (!bus.StallF) begin
      bus.PCF <= bus.PCNextF;
    end else begin
      bus.PCF <= bus.PCF;
    end
  end

  // IF/ID register: stall beats squash because branch operands are stale
  // while D is stalled. A squashed slot holds sll $0 (all zero).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.InstrD   <= 32'h0000_0000;
      bus.PCPlus4D <= 32'h0000_0000;
      bus.ValidD   <= 1'b0;
    end else if (bus.StallD) begin
      bus.InstrD   <= bus.InstrD;
      bus.PCPlus4D <= bus.PCPlus4D;
      bus.ValidD   <= bus.ValidD;
    end else if (bus.PCSrcD) begin
      bus.InstrD   <= 32'h0000_0000;
      bus.PCPlus4D <= 32'h0000_0000;
      bus.ValidD   <= 1'b0;
    end else begin
      bus.InstrD   <= bus.InstrF;
      bus.PCPlus4D <= bus.PCPlus4F;
      bus.ValidD   <= 1'b1;
    end
  end

  // ID/EX register: loads every cycle. A bubble is all-zero, and an all-zero
  // control bundle means no register write and no memory access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.CtrlE    <= {CTRL_W{1'b0}};
      bus.RD1E     <= 32'h0000_0000;
      bus.RD2E     <= 32'h0000_0000;
      bus.RsE      <= 5'd0;
      bus.RtE      <= 5'd0;
      bus.RdE      <= 5'd0;
      bus.SignImmE <= 32'h0000_0000;
      bus.ValidE   <= 1'b0;
    end else if (bus.FlushE) begin
      bus.CtrlE    <= {CTRL_W{1'b0}};
      bus.RD1E     <= 32'h0000_0000;
      bus.RD2E     <= 32'h0000_0000;
      bus.RsE      <= 5'd0;
      bus.RtE      <= 5'd0;
      bus.RdE      <= 5'd0;
      bus.SignImmE <= 32'h0000_0000;
      bus.ValidE   <= 1'b0;
    end else begin
      bus.CtrlE    <= bus.CtrlD;
      bus.RD1E     <= bus.RD1D;
      bus.RD2E     <= bus.RD2D;
      bus.RsE      <= bus.RsD;
      bus.RtE      <= bus.RtD;
      bus.RdE      <= bus.RdD;
      bus.SignImmE <= bus.SignImmD;
      bus.ValidE   <= bus.ValidD;
    end
  end

  // Stall counter: clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.StallCnt <= {COUNT_W{1'b0}};
    end else if (bus.CountClr) begin
      bus.StallCnt <= {COUNT_W{1'b0}};
    end else if (stallEvt) begin
      bus.StallCnt <= satInc(bus.StallCnt);
    end else begin
      bus.StallCnt <= bus.StallCnt;
    end
  end

  // Flush counter: clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.FlushCnt <= {COUNT_W{1'b0}};
    end else if (bus.CountClr) begin
      bus.FlushCnt <= {COUNT_W{1'b0}};
    end else if (flushEvt) begin
      bus.FlushCnt <= satInc(bus.FlushCnt);
    end else begin
      bus.FlushCnt <= bus.FlushCnt;
    end
  end

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs
//   Self-checking bench for pipe_front_regs with PC_RESET=0x00400000 and
//   COUNT_W=4 so counter saturation is reachable quickly. A directed vector
//   table covers streaming, load-use, branch and jump squashes; hand-written
//   sequences cover saturation, clear priority and reset mid-stall; a random
//   phase compares against a stage-record reference model.
module tb_pipe_front_regs;
  localparam logic [31:0] PCR  = 32'h0040_0000;
  localparam int          CW   = 10;
  localparam int          CNTW = 4;
  localparam int          MAXC = 15;

  logic clk = 1'b0;
  logic reset;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;

  pipe_front_regs_if #(.CTRL_W(CW), .COUNT_W(CNTW)) bus ();

  pipe_front_regs #(.PC_RESET(PCR), .CTRL_W(CW), .COUNT_W(CNTW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic sf, sd, fe, ps, clr;
    logic [31:0] pcNext, instrF;
    logic [9:0]  ctrlD;
    logic [31:0] ePcf, eInstrD;
    logic        eVd;
    logic [9:0]  eCtrlE;
    logic        eVe;
    logic [3:0]  eSc, eFc;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr, pc4;
    logic        valid;
  } dRec_t;

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        valid;
  } eRec_t;

  vec_t  tbl [9];
  dRec_t mD;
  eRec_t mE;
  logic [31:0] mPc;
  int    mStall, mFlush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic sf, sd, fe, ps, clr,
                       input logic [31:0] pcNext, pc4, instr,
                       input logic [9:0] ctrl);
    bus.StallF   = sf;
    bus.StallD   = sd;
    bus.FlushE   = fe;
    bus.PCSrcD   = ps;
    bus.CountClr = clr;
    bus.PCNextF  = pcNext;
    bus.PCPlus4F = pc4;
    bus.InstrF   = instr;
    bus.CtrlD    = ctrl;
    bus.RD1D     = 32'h0;
    bus.RD2D     = 32'h0;
    bus.SignImmD = 32'h0;
    bus.RsD      = 5'd0;
    bus.RtD      = 5'd0;
    bus.RdD      = 5'd0;
  endtask

  function automatic int satAdd(input int v);
    return (v + 1 > MAXC) ? MAXC : v + 1;
  endfunction

  initial begin
    // PCF, InstrD, ValidD, CtrlE, ValidE, StallCnt, FlushCnt after each edge
    tbl[0] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0040_0004, 32'h8C08_0004, 10'h001,
               32'h0040_0004, 32'h8C08_0004, 1'b1, 10'h001, 1'b0, 4'd0, 4'd0};
    tbl[1] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0040_0008, 32'h0109_4020, 10'h2A5,
               32'h0040_0008, 32'h0109_4020, 1'b1, 10'h2A5, 1'b1, 4'd0, 4'd0};
    tbl[2] = '{1'b1,1'b1,1'b1,1'b0,1'b0, 32'h0040_000C, 32'hDEAD_BEEF, 10'h3FF,
               32'h0040_0008, 32'h0109_4020, 1'b1, 10'h000, 1'b0, 4'd1, 4'd1};
    tbl[3] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0040_000C, 32'hAAAA_5555, 10'h155,
               32'h0040_000C, 32'hAAAA_5555, 1'b1, 10'h155, 1'b1, 4'd1, 4'd1};
    tbl[4] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0040_0100, 32'h1111_1111, 10'h0F0,
               32'h0040_0100, 32'h0000_0000, 1'b0, 10'h0F0, 1'b1, 4'd1, 4'd2};
    tbl[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0040_0104, 32'h2222_2222, 10'h00F,
               32'h0040_0104, 32'h2222_2222, 1'b1, 10'h00F, 1'b0, 4'd1, 4'd2};
    tbl[6] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 32'h0040_0200, 32'h3333_3333, 10'h111,
               32'h0040_0104, 32'h2222_2222, 1'b1, 10'h111, 1'b1, 4'd2, 4'd2};
    tbl[7] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0040_0300, 32'h4444_4444, 10'h222,
               32'h0040_0300, 32'h0000_0000, 1'b0, 10'h000, 1'b0, 4'd2, 4'd3};
    tbl[8] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 32'h0040_0400, 32'h5555_5555, 10'h333,
               32'h0040_0300, 32'h5555_5555, 1'b1, 10'h333, 1'b0, 4'd0, 4'd0};

    // Reset asserted from time 0; outputs must be valid before the first edge.
    reset = 1'b1;
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
    #2;
    chk("rst PCF",      bus.PCF, PCR);
    chk("rst InstrD",   bus.InstrD, 32'h0);
    chk("rst CtrlE",    32'(bus.CtrlE), 32'h0);
    chk("rst ValidD",   32'(bus.ValidD), 32'h0);
    chk("rst ValidE",   32'(bus.ValidE), 32'h0);
    chk("rst StallCnt", 32'(bus.StallCnt), 32'h0);
    chk("rst FlushCnt", 32'(bus.FlushCnt), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      setIn(tbl[i].sf, tbl[i].sd, tbl[i].fe, tbl[i].ps, tbl[i].clr,
            tbl[i].pcNext, tbl[i].pcNext, tbl[i].instrF, tbl[i].ctrlD);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d PCF", i),      bus.PCF, tbl[i].ePcf);
      chk($sformatf("v%0d InstrD", i),   bus.InstrD, tbl[i].eInstrD);
      chk($sformatf("v%0d ValidD", i),   32'(bus.ValidD), 32'(tbl[i].eVd));
      chk($sformatf("v%0d CtrlE", i),    32'(bus.CtrlE), 32'(tbl[i].eCtrlE));
      chk($sformatf("v%0d ValidE", i),   32'(bus.ValidE), 32'(tbl[i].eVe));
      chk($sformatf("v%0d StallCnt", i), 32'(bus.StallCnt), 32'(tbl[i].eSc));
      chk($sformatf("v%0d FlushCnt", i), 32'(bus.FlushCnt), 32'(tbl[i].eFc));
    end

    // Saturation: 20 stalled cycles leave StallCnt pinned at 15.
    for (int i = 0; i < 20; i++) begin
      setIn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0050_0000, 32'h0, 32'(i), 10'h0);
      @(posedge clk);
      #1;
    end
    chk("sat StallCnt", 32'(bus.StallCnt), 32'd15);
    chk("sat FlushCnt", 32'(bus.FlushCnt), 32'd0);
    chk("sat PCF",      bus.PCF, 32'h0040_0300);

    // Clear on the same edge as a stall wins.
    setIn(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 10'h0);
    @(posedge clk);
    #1;
    chk("clr StallCnt", 32'(bus.StallCnt), 32'd0);

    // Reset asserted between edges in the middle of a load-use stall.
    setIn(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 10'h0);
    @(posedge clk);
    #1;
    chk("pre StallCnt", 32'(bus.StallCnt), 32'd1);
    chk("pre FlushCnt", 32'(bus.FlushCnt), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("mid PCF",      bus.PCF, PCR);
    chk("mid InstrD",   bus.InstrD, 32'h0);
    chk("mid ValidD",   32'(bus.ValidD), 32'h0);
    chk("mid StallCnt", 32'(bus.StallCnt), 32'h0);
    chk("mid FlushCnt", 32'(bus.FlushCnt), 32'h0);
    setIn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PCR + 32'd4, PCR + 32'd4, 32'h0, 10'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rel PCF", bus.PCF, PCR);
    @(posedge clk);
    #1;
    chk("rel PCF+4", bus.PCF, PCR + 32'd4);
    chk("rel ValidD", 32'(bus.ValidD), 32'd1);
    chk("rel ValidE", 32'(bus.ValidE), 32'd0);

    // Reference model state after the edge just checked.
    mPc    = PCR + 32'd4;
    mD     = '{instr: 32'h0, pc4: PCR + 32'd4, valid: 1'b1};
    mE     = '0;
    mStall = 0;
    mFlush = 0;

    // Randomized phase.
    for (int c = 0; c < 600; c++) begin
      dRec_t nD;
      eRec_t nE;
      bus.StallF   = ($urandom_range(0, 3) == 0);
      bus.StallD   = ($urandom_range(0, 3) == 0);
      bus.FlushE   = ($urandom_range(0, 3) == 0);
      bus.PCSrcD   = ($urandom_range(0, 4) == 0);
      bus.CountClr = ($urandom_range(0, 40) == 0);
      bus.PCNextF  = $urandom;
      bus.PCPlus4F = $urandom;
      bus.InstrF   = $urandom;
      bus.CtrlD    = 10'($urandom);
      bus.RD1D     = $urandom;
      bus.RD2D     = $urandom;
      bus.SignImmD = $urandom;
      bus.RsD      = 5'($urandom);
      bus.RtD      = 5'($urandom);
      bus.RdD      = 5'($urandom);

      if (bus.StallD)      nD = mD;
      else if (bus.PCSrcD) nD = '0;
      else                 nD = '{instr: bus.InstrF, pc4: bus.PCPlus4F, valid: 1'b1};
      if (bus.FlushE) nE = '0;
      else nE = '{ctrl: bus.CtrlD, rd1: bus.RD1D, rd2: bus.RD2D, imm: bus.SignImmD,
                  rs: bus.RsD, rt: bus.RtD, rd: bus.RdD, valid: mD.valid};
      if (!bus.StallF) mPc = bus.PCNextF;
      if (bus.CountClr) begin
        mStall = 0;
        mFlush = 0;
      end else begin
        if (bus.StallF || bus.StallD) mStall = satAdd(mStall);
        if (bus.FlushE || (bus.PCSrcD && !bus.StallD)) mFlush = satAdd(mFlush);
      end
      mD = nD;
      mE = nE;

      @(posedge clk);
      #1;
      chk($sformatf("r%0d PCF", c),      bus.PCF, mPc);
      chk($sformatf("r%0d InstrD", c),   bus.InstrD, mD.instr);
      chk($sformatf("r%0d PCPlus4D", c), bus.PCPlus4D, mD.pc4);
      chk($sformatf("r%0d ValidD", c),   32'(bus.ValidD), 32'(mD.valid));
      chk($sformatf("r%0d CtrlE", c),    32'(bus.CtrlE), 32'(mE.ctrl));
      chk($sformatf("r%0d RD1E", c),     bus.RD1E, mE.rd1);
      chk($sformatf("r%0d RD2E", c),     bus.RD2E, mE.rd2);
      chk($sformatf("r%0d SignImmE", c), bus.SignImmE, mE.imm);
      chk($sformatf("r%0d RegsE", c),    32'({bus.RsE, bus.RtE, bus.RdE}),
                                         32'({mE.rs, mE.rt, mE.rd}));
      chk($sformatf("r%0d ValidE", c),   32'(bus.ValidE), 32'(mE.valid));
      chk($sformatf("r%0d StallCnt", c), 32'(bus.StallCnt), 32'(mStall));
      chk($sformatf("r%0d FlushCnt", c), 32'(bus.FlushCnt), 32'(mFlush));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
